usr_shift_reg: RTL and testbench

Parametrised universal shift register for the circuit-practice datapath; the successor of the fixed 4-bit serial-in shift register. Supports hold, shift right, shift left and parallel load, with per-direction serial inputs and a registered serial-out bit. Counts shifts since the last load and flags when every loaded bit has been shifted out. Feeds the serial-link and pattern-generator labs.

---
 rtl/usr_shift_if.sv | 16 +
 rtl/usr_shift_reg.sv | 52 +++++
 tb/tb_usr_shift_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/usr_shift_if.sv
// usr_shift_if: control, data and status bundle of usr_shift_reg.
interface usr_shift_if #(parameter int WIDTH = 4);
  localparam int CW = $clog2(WIDTH + 1);
  logic en;
  logic [1:0] mode;
  logic sin_r;
  logic sin_l;
  logic rotate;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] state;
  logic sout;
  logic [CW-1:0] cnt;
  logic drained;
  modport master (output en, mode, sin_r, sin_l, rotate, pdata, input state, sout, cnt, drained);
  modport slave (input en, mode, sin_r, sin_l, rotate, pdata, output state, sout, cnt, drained);
endinterface

// File: rtl/usr_shift_reg.sv
// usr_shift_reg: universal shift register (hold/right/left/load) with saturating shift count.
// Define USR_ROTATE_EN to make rotate=1 turn shifts circular.
module usr_shift_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic reset,
  usr_shift_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sout_q, sout_d, drained_q, drained_d;
  logic rot, shr, shl, ld, ins_r, ins_l;
`ifdef USR_ROTATE_EN
  assign rot = bus.rotate;
`else
  logic rotate_unused;
  assign rotate_unused = bus.rotate;
  assign rot = 1'b0;
`endif
  assign shr = bus.en && bus.mode == 2'b01;
  assign shl = bus.en && bus.mode == 2'b10;
  assign ld = bus.en && bus.mode == 2'b11;
  assign ins_r = rot ? state_q[0] : bus.sin_r;
  assign ins_l = rot ? state_q[WIDTH-1] : bus.sin_l;
  always_comb begin
    state_d = ld ? bus.pdata : shr ? {ins_r, state_q[WIDTH-1:1]} : shl ? {state_q[WIDTH-2:0], ins_l} : state_q;
    sout_d = ld ? 1'b0 : shr ? state_q[0] : shl ? state_q[WIDTH-1] : sout_q;
    // count total shifts regardless of direction, saturating at WIDTH
    cnt_d = ld ? '0 : ((shr || shl) && cnt_q != CW'(WIDTH)) ? cnt_q + CW'(1) : cnt_q;
    drained_d = cnt_d == CW'(WIDTH);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_VALUE;
      sout_q <= 1'b0;
      cnt_q <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q <= sout_d;
      cnt_q <= cnt_d;
      drained_q <= drained_d;
    end
  end
  assign bus.state = state_q;
  assign bus.sout = sout_q;
  assign bus.cnt = cnt_q;
  assign bus.drained = drained_q;
endmodule

// File: tb/tb_usr_shift_reg.sv
// tb_usr_shift_reg: scoreboard bench for usr_shift_reg against an arithmetic reference model.
module tb_usr_shift_reg;
  localparam int W = 4;
  localparam int RV = 4'b1010;
  localparam int MASK = (1 << W) - 1;
  typedef struct {int s; int o; int c; int d;} exp_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int ms, mo, mc, md;
  exp_t sb[$];
  usr_shift_if #(.WIDTH(W)) bus ();
  usr_shift_reg #(.WIDTH(W), .RESET_VALUE(4'b1010)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input bit e, input bit [1:0] m, input bit sr, input bit sl, input bit rt, input bit [3:0] pd);
    int rot, in;
    @(negedge clk);
    bus.en = e; bus.mode = m; bus.sin_r = sr; bus.sin_l = sl; bus.rotate = rt; bus.pdata = pd;
`ifdef USR_ROTATE_EN
    rot = int'(rt);
`else
    rot = 0;
`endif
    if (e && m == 2'b11) begin
      ms = int'(pd); mo = 0; mc = 0;
    end else if (e && m == 2'b01) begin
      in = rot ? (ms & 1) : int'(sr);
      mo = ms & 1;
      ms = (ms >> 1) | (in << (W - 1));
      mc = mc < W ? mc + 1 : W;
    end else if (e && m == 2'b10) begin
      mo = (ms >> (W - 1)) & 1;
      in = rot ? mo : int'(sl);
      ms = ((ms << 1) | in) & MASK;
      mc = mc < W ? mc + 1 : W;
    end
    md = int'(mc == W);
    sb.push_back('{ms, mo, mc, md});
  endtask
  task automatic settle();
    @(posedge clk);
    #2 bus.en = 1'b0;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1 bus.en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_state", int'(bus.state), RV);
    chk("rst_sout", int'(bus.sout), 0);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_drained", int'(bus.drained), 0);
    @(negedge clk);
    reset = 1'b1;
    ms = RV; mo = 0; mc = 0; md = 0;
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (int'(bus.state) != x.s || int'(bus.sout) != x.o || int'(bus.cnt) != x.c || int'(bus.drained) != x.d) begin
        errors++;
        $display("FAIL sb@%0t: got state=%b sout=%b cnt=%0d drained=%b, expected state=%04b sout=%0d cnt=%0d drained=%0d",
                 $time, bus.state, bus.sout, bus.cnt, bus.drained, x.s[3:0], x.o, x.c, x.d);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.mode = 2'b00; bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.rotate = 1'b0; bus.pdata = '0;
    ms = RV; mo = 0; mc = 0; md = 0;
    #1 reset = 1'b0;
    #1;
    chk("init_state", int'(bus.state), RV);
    chk("init_cnt", int'(bus.cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 2'b11, 0, 0, 0, 4'b0110);
    repeat (4) step(1, 2'b01, 1, 0, 0, 4'b0000);
    settle();
    chk("sr4_state", int'(bus.state), 4'b1111);
    chk("sr4_cnt", int'(bus.cnt), 4);
    chk("sr4_drained", int'(bus.drained), 1);
    step(1, 2'b01, 1, 0, 0, 4'b0000);
    settle();
    chk("sr5_cnt_sat", int'(bus.cnt), 4);
    chk("sr5_sout", int'(bus.sout), 1);
    step(1, 2'b11, 0, 0, 0, 4'b1001);
    repeat (2) step(1, 2'b10, 1, 0, 0, 4'b1111);
    repeat (3) step(0, 2'b11, 1, 1, 1, 4'b1111);
    settle();
    chk("hold_state", int'(bus.state), 4'b0100);
    chk("hold_cnt", int'(bus.cnt), 2);
    step(1, 2'b11, 0, 0, 0, 4'b1000);
    step(1, 2'b01, 0, 1, 0, 4'b1111);
    step(1, 2'b10, 0, 1, 0, 4'b1111);
    settle();
    chk("mix_state", int'(bus.state), 4'b1001);
    chk("mix_drained", int'(bus.drained), 0);
    step(1, 2'b11, 0, 0, 0, 4'b0000);
    settle();
    chk("reload_cnt", int'(bus.cnt), 0);
    step(1, 2'b11, 0, 0, 0, 4'b0111);
    repeat (3) step(1, 2'b10, 0, 1, 0, 4'b0000);
    pulse_reset();
    step(1, 2'b01, 1, 0, 0, 4'b0000);
    settle();
    chk("post_rst_cnt", int'(bus.cnt), 1);
    step(1, 2'b11, 0, 0, 0, 4'b0001);
    repeat (4) step(1, 2'b01, 0, 0, 1, 4'b0000);
    settle();
`ifdef USR_ROTATE_EN
    chk("rot_state", int'(bus.state), 4'b0001);
`else
    chk("rot_state", int'(bus.state), 4'b0000);
`endif
    chk("rot_drained", int'(bus.drained), 1);
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) pulse_reset();
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    end
    settle();
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
